qix_shared_ram_bridge: RTL and testbench
========================================

# qix_shared_ram_bridge

Video-side responder for the 2 KB shared RAM and FIRQ mailbox linking the Qix Data CPU and Video CPU. It arbitrates both CPUs' request/acknowledge ports onto one synchronous 2^ADDR_W x 8 RAM, one access per clock. It also holds the two cross-CPU FIRQ pending flags. The Data CPU board's shared RAM port and `firq_n` input terminate here, and the Video CPU board connects to the opposite port.

## Interface
- `ADDR_W`, 11: shared RAM address width (2048 bytes).
- `DATA_W`, 8: data width.

Ports:
- `clk_20m`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `d_req`  in  1  Data CPU access request; level, held until `d_ack`.
- `d_addr`  in  ADDR_W  Data CPU address.
- `d_we`  in  1  1 = write, 0 = read.
- `d_wdata`  in  DATA_W  write data.
- `d_rdata`  out  DATA_W  read data, registered, held until next Data read completes.
- `d_ack`  out  1  one-cycle completion pulse.
- `v_req`, `v_addr`, `v_we`, `v_wdata`, `v_rdata`, `v_ack`: identical set for the Video CPU.
- `d_firq_set`  in  1  Data CPU pulse: request FIRQ to the Video CPU.
- `v_firq_clr`  in  1  Video CPU pulse: acknowledge that FIRQ.
- `v_firq_set`  in  1  Video CPU pulse: request FIRQ to the Data CPU.
- `d_firq_clr`  in  1  Data CPU pulse: acknowledge that FIRQ.
- `v_firq_n`  out  1  active-low FIRQ to the Video CPU.
- `d_firq_n`  out  1  active-low FIRQ to the Data CPU; drives the Data board's `firq_n`.

## Operation
- Grant register `g` takes the values NONE, D, or V. Each edge:
  - `elig_d = d_req & (g != D)`
  - `elig_v = v_req & (g != V)`
- Arbitration:
  - If only one port is eligible, grant it.
  - If both are eligible, grant the port not granted most recently. The round-robin pointer `last` updates on every grant.
  - If neither is eligible, `g` = NONE.
- On a granted edge, the RAM operation executes. A write commits `wdata` to `addr` at that edge. A read captures `addr` at that edge.
- Back-to-back accesses to the same port are impossible, because the acked port is masked in its ack cycle. Alternating D/V accesses sustain one access per clock.
- No RAM collision exists since accesses are serialized. A write followed by a read of the same address returns the new data.
- Out-of-range addresses do not exist: the full `ADDR_W` range is decoded.
- Mailbox: `v_pend` is set by `d_firq_set` and cleared by `v_firq_clr`. `d_pend` is set by `v_firq_set` and cleared by `d_firq_clr`.
  - Simultaneous set and clear: set wins, so no event is lost.
  - `v_firq_n = ~v_pend`, `d_firq_n = ~d_pend`, both registered.
- RAM contents are not initialised and survive reset.

## Timing
- Reset values (asserted asynchronously on `reset_n` low):
  - `g` = NONE, `last` = V (so Data wins the first tie).
  - `d_ack` = `v_ack` = 0.
  - `d_rdata` = `v_rdata` = 0.
  - `v_firq_n` = `d_firq_n` = 1.
- Latency:
  - `req` is sampled high at edge k with the port granted.
  - `ack` is high for exactly the cycle after edge k.
  - For a read, `rdata` is valid in that same cycle and held afterwards.
  - Requester samples `ack` at edge k+1 and may drop or retarget `req` then.
  - Minimum per-port period is 2 cycles.
- `addr`, `we`, and `wdata` need only be stable at the granting edge.
- A `req` raised and dropped without ever being granted has no effect.
- FIRQ: `*_set` or `*_clr` at edge k changes `*_firq_n` in the cycle after edge k.
- Reset mid-access:
  - A write granted at the edge before reset assertion is committed.
  - A pending `ack` is lost and `rdata` clears to 0.
  - After `reset_n` rises, the first edge behaves as from IDLE.

## Test plan
- Reset: hold `reset_n` = 0 with random inputs → `d_ack`/`v_ack` = 0, `rdata` = 0, both `firq_n` = 1, no grants.
- Data write/read:
  - `d_req`, `d_we` = 1, `addr` 0x123, data 0xA5 → `d_ack` for one cycle.
  - Read of 0x123 → `d_ack` one cycle later, `d_rdata` = 0xA5.
- Simultaneous requests: first both-requesting edge after reset, Data writes 0x7FF = 0x11 and Video reads 0x7FF → Data is acked at cycle 1, Video at cycle 2 with `v_rdata` = 0x11.
- Continuous `d_req` and `v_req` held high → acks alternate D,V,D,V every cycle. With `v_req` low, `d_ack` pulses every second cycle.
- Mailbox:
  - `d_firq_set` pulse → `v_firq_n` = 0 next cycle; `v_firq_clr` → 1.
  - `v_firq_set` and `d_firq_clr` in the same cycle → `d_firq_n` = 0.
- Reset asserted in the ack cycle of a Data write of 0x3C to 0x000 → `d_ack` forced to 0. After release, reading 0x000 returns 0x3C.

Source files
------------

// File: rtl/qix_shared_ram_bridge.sv
// ---------------------------------------------------------------------------
// qix_shared_ram_bridge
//
// Purpose:
//   Video-side responder for the shared RAM and FIRQ mailbox between the Qix
//   Data CPU and Video CPU. Both CPUs' request/acknowledge ports are
//   arbitrated round-robin onto a single synchronous RAM, one access per
//   clock. The block also holds the two cross-CPU FIRQ pending flags.
//
// Ports:
//   clk_20m, reset_n         system clock, async active-low reset
//   d_req/d_addr/d_we/d_wdata Data CPU request (level, held until d_ack)
//   d_rdata, d_ack           Data CPU registered read data, 1-cycle ack
//   v_*                      identical port set for the Video CPU
//   d_firq_set, v_firq_clr   mailbox: Data -> Video FIRQ set / acknowledge
//   v_firq_set, d_firq_clr   mailbox: Video -> Data FIRQ set / acknowledge
//   v_firq_n, d_firq_n       registered active-low FIRQ outputs
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module qix_shared_ram_bridge #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk_20m,
  input  logic              reset_n,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  input  logic              v_req,
  input  logic [ADDR_W-1:0] v_addr,
  input  logic              v_we,
  input  logic [DATA_W-1:0] v_wdata,
  output logic [DATA_W-1:0] v_rdata,
  output logic              v_ack,
  input  logic              d_firq_set,
  input  logic              v_firq_clr,
  input  logic              v_firq_set,
  input  logic              d_firq_clr,
  output logic              v_firq_n,
  output logic              d_firq_n
);

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_D    = 2'd1,
    G_V    = 2'd2
  } grant_e;

  grant_e              g_q, g_d;
  logic                last_v_q;   // 1: Video received the most recent grant
  logic                elig_d, elig_v;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W-1:0]   d_rdata_q, v_rdata_q;
  logic                d_ack_q, v_ack_q;
  logic                v_firq_n_q, d_firq_n_q;

  // RAM storage: no reset, contents survive reset_n
  logic [DATA_W-1:0]   mem_q [2**ADDR_W];

  // The port acked this cycle is masked so each port gets at most every
  // second edge; on a tie the port not granted most recently wins.
  always_comb begin
    elig_d = d_req & (g_q != G_D);
    elig_v = v_req & (g_q != G_V);
    g_d    = G_NONE;
    if (elig_d && (!elig_v || last_v_q)) begin
      g_d = G_D;
    end else if (elig_v) begin
      g_d = G_V;
    end
  end

  // Write port selection; reset_n gating keeps held requests from touching
  // the RAM while the bridge is in reset.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = d_addr;
    wr_data = d_wdata;
    if (reset_n) begin
      if (g_d == G_D) begin
        wr_en = d_we;
      end else if (g_d == G_V) begin
        wr_en   = v_we;
        wr_addr = v_addr;
        wr_data = v_wdata;
      end
    end
  end

  always_ff @(posedge clk_20m) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Grant state, acks, read-data holding registers and mailbox flags
  always_ff @(posedge clk_20m or negedge reset_n) begin
    if (!reset_n) begin
      g_q        <= G_NONE;
      last_v_q   <= 1'b1;
      d_ack_q    <= 1'b0;
      v_ack_q    <= 1'b0;
      d_rdata_q  <= '0;
      v_rdata_q  <= '0;
      v_firq_n_q <= 1'b1;
      d_firq_n_q <= 1'b1;
    end else begin
      g_q     <= g_d;
      d_ack_q <= (g_d == G_D);
      v_ack_q <= (g_d == G_V);
      if (g_d == G_D) begin
        last_v_q <= 1'b0;
        if (!d_we) begin
          d_rdata_q <= mem_q[d_addr];
        end
      end else if (g_d == G_V) begin
        last_v_q <= 1'b1;
        if (!v_we) begin
          v_rdata_q <= mem_q[v_addr];
        end
      end
      // Set has priority over clear so a new FIRQ is never lost
      if (d_firq_set) begin
        v_firq_n_q <= 1'b0;
      end else if (v_firq_clr) begin
        v_firq_n_q <= 1'b1;
      end
      if (v_firq_set) begin
        d_firq_n_q <= 1'b0;
      end else if (d_firq_clr) begin
        d_firq_n_q <= 1'b1;
      end
    end
  end

  assign d_ack    = d_ack_q;
  assign v_ack    = v_ack_q;
  assign d_rdata  = d_rdata_q;
  assign v_rdata  = v_rdata_q;
  assign v_firq_n = v_firq_n_q;
  assign d_firq_n = d_firq_n_q;

endmodule

// File: tb/tb_qix_shared_ram_bridge.sv
// ---------------------------------------------------------------------------
// tb_qix_shared_ram_bridge
//
// Directed testbench for qix_shared_ram_bridge. Each task exercises one
// feature with hand-computed expected values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_qix_shared_ram_bridge;

  logic        clk_20m = 1'b0;
  logic        reset_n;
  logic        d_req, d_we, v_req, v_we;
  logic [10:0] d_addr, v_addr;
  logic [7:0]  d_wdata, v_wdata, d_rdata, v_rdata;
  logic        d_ack, v_ack;
  logic        d_firq_set, v_firq_clr, v_firq_set, d_firq_clr;
  logic        v_firq_n, d_firq_n;

  int checks = 0;
  int errors = 0;

  qix_shared_ram_bridge #(.ADDR_W(11), .DATA_W(8)) dut (
    .clk_20m    (clk_20m),
    .reset_n    (reset_n),
    .d_req      (d_req),
    .d_addr     (d_addr),
    .d_we       (d_we),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_ack      (d_ack),
    .v_req      (v_req),
    .v_addr     (v_addr),
    .v_we       (v_we),
    .v_wdata    (v_wdata),
    .v_rdata    (v_rdata),
    .v_ack      (v_ack),
    .d_firq_set (d_firq_set),
    .v_firq_clr (v_firq_clr),
    .v_firq_set (v_firq_set),
    .d_firq_clr (d_firq_clr),
    .v_firq_n   (v_firq_n),
    .d_firq_n   (d_firq_n)
  );

  always #5 clk_20m = ~clk_20m;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk_20m);
    #1;
  endtask

  task automatic clear_inputs();
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    v_req = 0; v_we = 0; v_addr = '0; v_wdata = '0;
    d_firq_set = 0; v_firq_clr = 0; v_firq_set = 0; d_firq_clr = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
  endtask

  // Data access: raise req, wait (bounded) for ack, drop req in the ack cycle
  task automatic d_access(input logic we, input logic [10:0] addr,
                          input logic [7:0] wdata, output int cycles);
    d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1;
    cycles = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      cycles++;
      if (d_ack) break;
    end
    d_req = 0;
    checks++;
    if (d_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL d_access_timeout: d_ack=%b required 1 addr=%h", d_ack, addr);
    end
  endtask

  task automatic v_access(input logic we, input logic [10:0] addr,
                          input logic [7:0] wdata, output int cycles);
    v_we = we; v_addr = addr; v_wdata = wdata; v_req = 1;
    cycles = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      cycles++;
      if (v_ack) break;
    end
    v_req = 0;
    checks++;
    if (v_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL v_access_timeout: v_ack=%b required 1 addr=%h", v_ack, addr);
    end
  endtask

  task automatic test_reset();
    reset_n = 0;
    for (int i = 0; i < 5; i++) begin
      d_req = 1'($urandom); d_we = 1'($urandom);
      d_addr = 11'($urandom); d_wdata = 8'($urandom);
      v_req = 1'($urandom); v_we = 1'($urandom);
      v_addr = 11'($urandom); v_wdata = 8'($urandom);
      d_firq_set = 1'($urandom); v_firq_clr = 1'($urandom);
      v_firq_set = 1'($urandom); d_firq_clr = 1'($urandom);
      tick();
      checks++;
      if ({d_ack, v_ack, d_rdata, v_rdata, v_firq_n, d_firq_n} !== {2'b00, 16'h0000, 2'b11}) begin
        errors++;
        $display("[TB] FAIL reset_state: ack=%b%b rdata=%h/%h firq_n=%b%b required 00 00/00 11",
                 d_ack, v_ack, d_rdata, v_rdata, v_firq_n, d_firq_n);
      end
    end
    clear_inputs();
    reset_n = 1;
  endtask

  task automatic test_data_write_read();
    int c;
    d_access(1'b1, 11'h123, 8'hA5, c);
    checks++;
    if (c !== 1) begin
      errors++;
      $display("[TB] FAIL d_write_latency: got %0d cycles required 1", c);
    end
    tick();
    checks++;
    if (d_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL d_ack_one_cycle: d_ack=%b required 0", d_ack);
    end
    d_access(1'b0, 11'h123, 8'h00, c);
    checks++;
    if (c !== 1 || d_rdata !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL d_read_123: cycles=%0d rdata=%h required 1 A5", c, d_rdata);
    end
    // Video overwrites the byte; Data's read register must hold old value
    v_access(1'b1, 11'h123, 8'h5A, c);
    checks++;
    if (d_rdata !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL d_rdata_hold: got %h required A5", d_rdata);
    end
    tick();
    v_access(1'b0, 11'h123, 8'h00, c);
    checks++;
    if (v_rdata !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL v_read_123: got %h required 5A", v_rdata);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    d_we = 1; d_addr = 11'h7FF; d_wdata = 8'h11; d_req = 1;
    v_we = 0; v_addr = 11'h7FF; v_req = 1;
    tick();
    checks++;
    if (d_ack !== 1'b1 || v_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tie_cycle1: d_ack=%b v_ack=%b required 1 0", d_ack, v_ack);
    end
    d_req = 0;
    tick();
    checks++;
    if (d_ack !== 1'b0 || v_ack !== 1'b1 || v_rdata !== 8'h11) begin
      errors++;
      $display("[TB] FAIL tie_cycle2: d_ack=%b v_ack=%b v_rdata=%h required 0 1 11",
               d_ack, v_ack, v_rdata);
    end
    v_req = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_d;
    do_reset();
    d_we = 0; v_we = 0; d_addr = 11'h010; v_addr = 11'h020;
    d_req = 1; v_req = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_d = (i % 2 == 0);
      checks++;
      if (d_ack !== exp_d || v_ack !== ~exp_d) begin
        errors++;
        $display("[TB] FAIL alternate_%0d: d_ack=%b v_ack=%b required %b %b",
                 i, d_ack, v_ack, exp_d, ~exp_d);
      end
    end
    v_req = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_d = (i % 2 == 0);
      checks++;
      if (d_ack !== exp_d || v_ack !== 1'b0) begin
        errors++;
        $display("[TB] FAIL d_only_%0d: d_ack=%b v_ack=%b required %b 0",
                 i, d_ack, v_ack, exp_d);
      end
    end
    d_req = 0;
    tick();
  endtask

  task automatic test_mailbox();
    d_firq_set = 1; tick(); d_firq_set = 0;
    checks++;
    if (v_firq_n !== 1'b0 || d_firq_n !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mbox_d_set: v_firq_n=%b d_firq_n=%b required 0 1", v_firq_n, d_firq_n);
    end
    tick();
    checks++;
    if (v_firq_n !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mbox_v_hold: v_firq_n=%b required 0", v_firq_n);
    end
    v_firq_clr = 1; tick(); v_firq_clr = 0;
    checks++;
    if (v_firq_n !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mbox_v_clr: v_firq_n=%b required 1", v_firq_n);
    end
    v_firq_set = 1; d_firq_clr = 1; tick(); v_firq_set = 0; d_firq_clr = 0;
    checks++;
    if (d_firq_n !== 1'b0 || v_firq_n !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mbox_d_set_wins: d_firq_n=%b v_firq_n=%b required 0 1", d_firq_n, v_firq_n);
    end
    d_firq_set = 1; v_firq_clr = 1; tick(); d_firq_set = 0; v_firq_clr = 0;
    checks++;
    if (v_firq_n !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mbox_v_set_wins: v_firq_n=%b required 0", v_firq_n);
    end
    d_firq_clr = 1; tick(); d_firq_clr = 0;
    checks++;
    if (d_firq_n !== 1'b1 || v_firq_n !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mbox_d_clr: d_firq_n=%b v_firq_n=%b required 1 0", d_firq_n, v_firq_n);
    end
  endtask

  task automatic test_reset_mid_access();
    int c;
    d_access(1'b1, 11'h000, 8'h3C, c);
    reset_n = 0;
    #1;
    checks++;
    if (d_ack !== 1'b0 || d_rdata !== 8'h00 || v_rdata !== 8'h00 ||
        v_firq_n !== 1'b1 || d_firq_n !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_access: d_ack=%b rdata=%h/%h firq_n=%b%b required 0 00/00 11",
               d_ack, d_rdata, v_rdata, v_firq_n, d_firq_n);
    end
    tick();
    tick();
    reset_n = 1;
    d_access(1'b0, 11'h000, 8'h00, c);
    checks++;
    if (c !== 1 || d_rdata !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL write_survives_reset: cycles=%0d rdata=%h required 1 3C", c, d_rdata);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clear_inputs();
    reset_n = 0;
    test_reset();
    test_data_write_read();
    test_simultaneous();
    test_back_to_back();
    test_mailbox();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
